// File: rtl/gf163_clmul_serial_if.sv
// gf163_clmul_serial_if: operand/result bundle between the multiplier and its requester.
interface gf163_clmul_serial_if #(parameter int M = 163);
  logic           start;
  logic [M-1:0]   a;
  logic [M-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*M-2:0] p;
  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/gf163_clmul_serial.sv
// gf163_clmul_serial: digit-serial carry-less multiplier, D bits of b per clock, MSB digit first.
module gf163_clmul_serial #(
  parameter int M = 163,
  parameter int D = 8
) (
  input logic               clk,
  input logic               rst,
  gf163_clmul_serial_if.slave bus
);
  localparam int N  = (M + D - 1) / D;
  localparam int NB = N * D;
  localparam int W  = 2 * M - 1;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state_q, state_d;
  logic [M-1:0]    a_q, a_d;
  logic [NB-1:0]   b_q, b_d;
  logic [W-1:0]    acc_q, acc_d, p_q, p_d, acc_nx, pp_ext;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [D-1:0]    digit;
  logic [M+D-2:0]  a_ext, pp;
  // One digit step: shift the running sum up by D and fold in a_r times the current digit.
  always_comb begin
    digit = b_q[cnt_q*D +: D];
    a_ext = '0;
    a_ext[M-1:0] = a_q;
    pp = '0;
    for (int j = 0; j < D; j++) pp = pp ^ (digit[j] ? (a_ext << j) : '0);
    pp_ext = '0;
    pp_ext[M+D-2:0] = pp;
    acc_nx = (acc_q << D) ^ pp_ext;
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    if (state_q == IDLE && bus.start) begin
      a_d          = bus.a;
      b_d          = '0;
      b_d[M-1:0]   = bus.b;
      acc_d        = '0;
      cnt_d        = CW'(N - 1);
      state_d      = RUN;
    end else if (state_q == RUN) begin
      acc_d = acc_nx;
      if (cnt_q == '0) begin
        p_d     = acc_nx;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.p    = p_q;
endmodule

// File: tb/tb_gf163_clmul_serial.sv
// tb_gf163_clmul_serial: directed checks of the serial GF(2)[x] multiplier at D=8, plus D=1/D=32 cross-checks.
module tb_gf163_clmul_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int ncmp = 0;
  int nfail = 0;
  always #5 clk = ~clk;
  gf163_clmul_serial_if #(.M(163)) i1 ();
  gf163_clmul_serial_if #(.M(163)) i8 ();
  gf163_clmul_serial_if #(.M(163)) i32 ();
  gf163_clmul_serial #(.M(163), .D(1))  d1  (.clk(clk), .rst(rst), .bus(i1.slave));
  gf163_clmul_serial #(.M(163), .D(8))  d8  (.clk(clk), .rst(rst), .bus(i8.slave));
  gf163_clmul_serial #(.M(163), .D(32)) d32 (.clk(clk), .rst(rst), .bus(i32.slave));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [324:0] obs, input logic [324:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chkn(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [162:0] rnd163();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[162:0];
  endfunction
  // Bitwise schoolbook reference: one shifted copy of x per set bit of y.
  function automatic logic [324:0] clmul_ref(input logic [162:0] x, input logic [162:0] y);
    logic [324:0] r;
    r = '0;
    for (int i = 0; i < 163; i++) if (y[i]) r = r ^ ({162'b0, x} << i);
    return r;
  endfunction
  task automatic run8(input string tag, input logic [162:0] av, input logic [162:0] bv, input logic [324:0] exp);
    int n;
    int bc;
    n = 0;
    bc = 0;
    i8.a = av;
    i8.b = bv;
    i8.start = 1'b1;
    step();
    i8.start = 1'b0;
    chk1({tag, "_busy_after_accept"}, i8.busy, 1'b1);
    while (!i8.done && n < 60) begin
      if (i8.busy) bc++;
      step();
      n++;
    end
    chkn({tag, "_latency"}, n, 21);
    chkn({tag, "_busy_cycles"}, bc, 21);
    chk1({tag, "_busy_at_done"}, i8.busy, 1'b0);
    chk({tag, "_p"}, i8.p, exp);
    step();
    chk1({tag, "_done_pulse_end"}, i8.done, 1'b0);
  endtask
  initial begin
    logic [162:0] ones;
    logic [162:0] hi;
    logic [324:0] sq_ones;
    logic [324:0] e;
    logic [324:0] pr;
    logic [324:0] p1, p8, p32;
    logic g1, g8, g32;
    logic [162:0] av, bv;
    int dn;
    ones = '1;
    hi = 163'b1 << 162;
    sq_ones = '0;
    for (int i = 0; i < 163; i++) sq_ones[2*i] = 1'b1;
    i1.start = 0; i1.a = '0; i1.b = '0;
    i8.start = 0; i8.a = '0; i8.b = '0;
    i32.start = 0; i32.a = '0; i32.b = '0;
    #12;
    chk1("rst_busy", i8.busy, 1'b0);
    chk1("rst_done", i8.done, 1'b0);
    chk("rst_p", i8.p, 325'b0);
    chk("rst_p_d1", i1.p, 325'b0);
    chk("rst_p_d32", i32.p, 325'b0);
    step();
    rst = 1'b0;
    step();
    run8("one", 163'd1, 163'd1, 325'd1);
    run8("x162sq", hi, hi, 325'b1 << 324);
    run8("xp1sq", 163'd3, 163'd3, 325'd5);
    run8("ff_sq", 163'hff, 163'hff, 325'h5555);
    run8("ones_x_1", ones, 163'd1, {162'b0, ones});
    run8("one_x_ones", 163'd1, ones, {162'b0, ones});
    run8("x162_x_ones", hi, ones, {162'b0, ones} << 162);
    run8("ones_sq", ones, ones, sq_ones);
    // Operands and start churn during RUN must not disturb the captured multiplication.
    i8.a = 163'h5;
    i8.b = 163'h7;
    i8.start = 1'b1;
    step();
    dn = 0;
    pr = '0;
    for (int c = 0; c < 40; c++) begin
      if (i8.done) begin
        dn++;
        pr = i8.p;
      end
      if (i8.busy) begin
        i8.a = rnd163();
        i8.b = rnd163();
        i8.start = ~i8.start;
      end else begin
        i8.start = 1'b0;
      end
      step();
    end
    chkn("toggle_done_count", dn, 1);
    chk("toggle_p", pr, 325'h1b);
    chk("toggle_p_hold", i8.p, 325'h1b);
    chk1("toggle_idle", i8.busy, 1'b0);
    i8.a = ones;
    i8.b = ones;
    i8.start = 1'b1;
    step();
    i8.start = 1'b0;
    repeat (9) step();
    chk1("abort_busy_before", i8.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("abort_busy", i8.busy, 1'b0);
    chk1("abort_done", i8.done, 1'b0);
    chk("abort_p", i8.p, 325'b0);
    step();
    step();
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      if (i8.done) dn++;
      step();
    end
    chkn("abort_no_done", dn, 0);
    chk("abort_p_stays", i8.p, 325'b0);
    run8("after_abort", 163'd2, 163'd3, 325'd6);
    // All three digit widths run the same operands side by side against the bitwise reference.
    for (int k = 0; k < 25; k++) begin
      av = (k == 0) ? ones : rnd163();
      bv = (k == 0) ? hi : rnd163();
      e = clmul_ref(av, bv);
      i1.a = av; i8.a = av; i32.a = av;
      i1.b = bv; i8.b = bv; i32.b = bv;
      i1.start = 1'b1; i8.start = 1'b1; i32.start = 1'b1;
      step();
      i1.start = 1'b0; i8.start = 1'b0; i32.start = 1'b0;
      g1 = 0; g8 = 0; g32 = 0;
      p1 = '0; p8 = '0; p32 = '0;
      for (int c = 0; c < 200 && !(g1 && g8 && g32); c++) begin
        if (i1.done && !g1) begin g1 = 1; p1 = i1.p; end
        if (i8.done && !g8) begin g8 = 1; p8 = i8.p; end
        if (i32.done && !g32) begin g32 = 1; p32 = i32.p; end
        step();
      end
      chk1("rand_done_d1", g1, 1'b1);
      chk1("rand_done_d8", g8, 1'b1);
      chk1("rand_done_d32", g32, 1'b1);
      chk("rand_p_d1", p1, e);
      chk("rand_p_d8", p8, e);
      chk("rand_p_d32", p32, e);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
